// File: rtl/reg4_seq_ctrl.sv
// reg4_seq_ctrl: owns the serial/parallel register and runs one command per start strobe
// (load, serial shift-in, rotate-left by N, clear) with busy/done handshake.
module reg4_seq_ctrl #(
    parameter int                   NBITS_REG = 4,
    parameter logic [NBITS_REG-1:0] RESET_REG = '0,
    parameter int                   CNT_W     = 2
) (
    input  logic                 clk_2,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [NBITS_REG-1:0] din_par,
    input  logic                 din_ser,
    input  logic [CNT_W-1:0]     rot_amt,
    input  logic                 abort,
    output logic [NBITS_REG-1:0] reg_q,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     bit_cnt
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, ROTATE, CLEAR, DONE} state_t;

    state_t               state, state_d;
    logic [NBITS_REG-1:0] reg_d, data_l, data_d;
    logic [CNT_W-1:0]     cnt_d, rot_l, rot_d;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            reg_q   <= RESET_REG;
            bit_cnt <= '0;
            data_l  <= '0;
            rot_l   <= '0;
        end else begin
            state   <= state_d;
            reg_q   <= reg_d;
            bit_cnt <= cnt_d;
            data_l  <= data_d;
            rot_l   <= rot_d;
        end
    end

    always_comb begin
        state_d = state;
        reg_d   = reg_q;
        cnt_d   = bit_cnt;
        data_d  = data_l;
        rot_d   = rot_l;
        case (state)
            IDLE: begin
                if (start) begin
                    data_d  = din_par;
                    rot_d   = rot_amt;
                    state_d = (mode == 2'b00) ? LOAD :
                              (mode == 2'b01) ? SHIFT :
                              (mode == 2'b10) ? ((rot_amt == '0) ? DONE : ROTATE) : CLEAR;
                end
            end
            LOAD: begin
                reg_d   = data_l;
                state_d = DONE;
            end
            SHIFT: begin
                reg_d   = {reg_q[NBITS_REG-2:0], din_ser};
                cnt_d   = bit_cnt + 1'b1;
                state_d = (bit_cnt == CNT_W'(NBITS_REG - 1)) ? DONE : SHIFT;
            end
            ROTATE: begin
                reg_d   = {reg_q[NBITS_REG-2:0], reg_q[NBITS_REG-1]};
                cnt_d   = bit_cnt + 1'b1;
                state_d = (bit_cnt == rot_l - 1'b1) ? DONE : ROTATE;
            end
            CLEAR: begin
                reg_d   = RESET_REG;
                state_d = DONE;
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        // abort overrides everything outside IDLE, including the final shift/rotate
        if (abort && state != IDLE) begin
            state_d = IDLE;
            reg_d   = reg_q;
            cnt_d   = '0;
        end
    end

endmodule

// File: tb/tb_reg4_seq_ctrl.sv
// tb_reg4_seq_ctrl: directed and randomized commands against a word-level model
// of the register and of each command's cycle count.
module tb_reg4_seq_ctrl;

    logic       clk_2 = 1'b0, reset_n = 1'b0, start = 1'b0, din_ser = 1'b0, abort = 1'b0;
    logic [1:0] mode = '0, rot_amt = '0;
    logic [3:0] din_par = '0;
    logic [3:0] reg_q;
    logic       busy, done;
    logic [1:0] bit_cnt;

    int         checks = 0, errors = 0;
    logic [3:0] model = '0;

    reg4_seq_ctrl dut (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .start   (start),
        .mode    (mode),
        .din_par (din_par),
        .din_ser (din_ser),
        .rot_amt (rot_amt),
        .abort   (abort),
        .reg_q   (reg_q),
        .busy    (busy),
        .done    (done),
        .bit_cnt (bit_cnt)
    );

    always #5 clk_2 = ~clk_2;

    task automatic tick;
        @(posedge clk_2);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] v, input int n);
        logic [7:0] w;
        w = {v, v} << n;
        return w[7:4];
    endfunction

    // value after n serial shifts of ser (MSB first) into v
    function automatic logic [3:0] shin(input logic [3:0] v, input logic [3:0] ser, input int n);
        logic [7:0] w;
        w = {v, ser} << n;
        return w[7:4];
    endfunction

    // abort_at: -1 none, -2 abort together with start in IDLE, i>=0 abort after i working edges
    task automatic run_cmd(input logic [1:0] m, input logic [3:0] d, input logic [1:0] r,
                           input logic [3:0] ser, input int abort_at);
        int         lat;
        logic [3:0] fin, part;
        lat = (m == 2'b01) ? 4 : (m == 2'b10) ? int'(r) : 1;
        fin = (m == 2'b00) ? d : (m == 2'b01) ? ser : (m == 2'b10) ? rotl(model, int'(r)) : 4'h0;
        mode    = m;
        din_par = d;
        rot_amt = r;
        start   = 1'b1;
        abort   = (abort_at == -2);
        tick;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < lat; i++) begin
            din_ser = ser[2'(3 - i)];
            mode    = 2'($urandom);
            din_par = 4'($urandom);
            rot_amt = 2'($urandom);
            start   = 1'($urandom);
            part = (m == 2'b01) ? shin(model, ser, i) : (m == 2'b10) ? rotl(model, i) : model;
            chk("busy_run", 4'(busy), 4'd1);
            chk("done_run", 4'(done), 4'd0);
            chk("reg_run", reg_q, part);
            if (m == 2'b01 || m == 2'b10) chk("cnt_run", 4'(bit_cnt), 4'(i));
            if (i == abort_at) begin
                abort = 1'b1;
                tick;
                abort = 1'b0;
                start = 1'b0;
                model = part;
                chk("abort_busy", 4'(busy), 4'd0);
                chk("abort_done", 4'(done), 4'd0);
                chk("abort_reg", reg_q, model);
                chk("abort_cnt", 4'(bit_cnt), 4'd0);
                return;
            end
            tick;
        end
        chk("done_pulse", 4'(done), 4'd1);
        chk("done_busy", 4'(busy), 4'd1);
        chk("done_reg", reg_q, fin);
        chk("done_cnt", 4'(bit_cnt), (m == 2'b10) ? 4'(r) : 4'd0);
        start = 1'($urandom);
        tick;
        start = 1'b0;
        model = fin;
        chk("idle_done", 4'(done), 4'd0);
        chk("idle_busy", 4'(busy), 4'd0);
        chk("idle_reg", reg_q, model);
        chk("idle_cnt", 4'(bit_cnt), 4'd0);
    endtask

    initial begin
        #12;
        chk("rst_reg", reg_q, 4'h0);
        chk("rst_busy", 4'(busy), 4'd0);
        chk("rst_done", 4'(done), 4'd0);
        chk("rst_cnt", 4'(bit_cnt), 4'd0);
        reset_n = 1'b1;
        tick;
        tick;
        chk("idle_hold", 4'(busy), 4'd0);
        run_cmd(2'b00, 4'b1010, 2'd0, 4'h0, -1);
        run_cmd(2'b11, 4'h0, 2'd0, 4'h0, -1);
        run_cmd(2'b01, 4'h0, 2'd0, 4'b1101, -1);
        run_cmd(2'b00, 4'b1001, 2'd0, 4'h0, -1);
        run_cmd(2'b10, 4'h0, 2'd3, 4'h0, -1);
        run_cmd(2'b00, 4'b1001, 2'd0, 4'h0, -1);
        run_cmd(2'b10, 4'h0, 2'd0, 4'h0, -1);
        run_cmd(2'b01, 4'h0, 2'd0, 4'b1101, 2);
        run_cmd(2'b11, 4'h0, 2'd0, 4'h0, -1);
        run_cmd(2'b01, 4'h0, 2'd0, 4'b0110, 3);
        run_cmd(2'b00, 4'b0110, 2'd0, 4'h0, -2);
        run_cmd(2'b10, 4'h0, 2'd3, 4'h0, 1);
        tick;
        chk("idle_abort_noop", 4'(busy), 4'd0);
        run_cmd(2'b00, 4'b1001, 2'd0, 4'h0, -1);
        mode    = 2'b10;
        rot_amt = 2'd3;
        start   = 1'b1;
        tick;
        start = 1'b0;
        tick;
        #3 reset_n = 1'b0;
        #1;
        model = 4'h0;
        chk("arst_reg", reg_q, model);
        chk("arst_busy", 4'(busy), 4'd0);
        chk("arst_done", 4'(done), 4'd0);
        chk("arst_cnt", 4'(bit_cnt), 4'd0);
        #2 reset_n = 1'b1;
        tick;
        chk("post_rst_reg", reg_q, 4'h0);
        run_cmd(2'b00, 4'b0111, 2'd0, 4'h0, -1);
        for (int n = 0; n < 80; n++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) :
                 ($urandom_range(0, 7) == 0) ? -2 : -1;
            run_cmd(2'($urandom), 4'($urandom), 2'($urandom), 4'($urandom), ab);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
